// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encoding, FSM states and fixed latency shared by the multiply/divide unit
package muldiv_pkg;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;
  localparam int MULDIV_LATENCY = 34;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift/accumulate registers, one multiply or restoring-divide step per cycle; signed correction when MULDIV_SIGNED_EN is defined
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] busA_i,
  input  logic [WIDTH-1:0] busB_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, a_q, ma, mb;
  logic div_q, neg_q, rneg_q, dbz_q, sgn, sa, sb, div_op;
  logic [WIDTH:0] madd, trial, diff;
  logic [2*WIDTH-1:0] prod_neg;
`ifdef MULDIV_SIGNED_EN
  assign sgn = ~op_i[0];
`else
  // op[0] carries no meaning without signed support; it is folded to zero here
  assign sgn = op_i[0] & 1'b0;
`endif
  assign div_op = op_i[1];
  assign sa = sgn & busA_i[WIDTH-1];
  assign sb = sgn & busB_i[WIDTH-1];
  assign ma = sa ? -busA_i : busA_i;
  assign mb = sb ? -busB_i : busB_i;
  // hi_q accumulates the partial product for multiply and the partial remainder for divide
  assign madd = lo_q[0] ? {1'b0, hi_q} + {1'b0, m_q} : {1'b0, hi_q};
  assign trial = {hi_q, lo_q[WIDTH-1]};
  assign diff = trial - {1'b0, m_q};
  assign prod_neg = -{hi_q, lo_q};
  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign dbz_o = dbz_q;
  // next value of the shared HI/LO working pair: load, step, then sign fix or forced divide-by-zero result
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = div_op ? ma : mb;
    end else if (step_i && div_q) begin
      hi_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else if (step_i) begin
      hi_d = madd[WIDTH:1];
      lo_d = {madd[0], lo_q[WIDTH-1:1]};
    end else if (fix_i && dbz_q) begin
      hi_d = a_q;
      lo_d = '1;
    end else if (fix_i && div_q) begin
      hi_d = rneg_q ? -hi_q : hi_q;
      lo_d = neg_q ? -lo_q : lo_q;
    end else if (fix_i && neg_q) begin
      {hi_d, lo_d} = prod_neg;
    end
  end
  // working registers plus operand magnitude and sign bookkeeping captured at the accepting edge
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      a_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (load_i) begin
        m_q <= div_op ? mb : ma;
        a_q <= busA_i;
        div_q <= div_op;
        neg_q <= sa ^ sb;
        rneg_q <= sa;
        dbz_q <= div_op && busB_i == '0;
      end
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and start/busy/done handshake; signed ops under MULDIV_SIGNED_EN
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] busA_i,
  input  logic [WIDTH-1:0] busB_i,
  input  logic             hilo_sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, dp_hi, dp_lo;
  logic busy_q, done_q, dbz_q, dp_dbz, load, step, fix;
  assign load = state_q == S_IDLE && start_i;
  assign step = state_q == S_RUN;
  assign fix = state_q == S_FIX;
  assign result_o = hilo_sel_i ? hi_q : lo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign div_by_zero_o = dbz_q;
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .load_i  (load),
    .step_i  (step),
    .fix_i   (fix),
    .op_i    (op_i),
    .busA_i  (busA_i),
    .busB_i  (busB_i),
    .hi_o    (dp_hi),
    .lo_o    (dp_lo),
    .dbz_o   (dp_dbz)
  );
  // control FSM: WIDTH run steps, one fix cycle, then a single-cycle commit of HI/LO with done
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          state_q <= S_RUN;
          cnt_q <= '0;
          busy_q <= 1'b1;
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_FIX: state_q <= S_DONE;
        S_DONE: begin
          hi_q <= dp_hi;
          lo_q <= dp_lo;
          done_q <= 1'b1;
          dbz_q <= dp_dbz;
          busy_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative integer multiply/divide unit with HI/LO result registers. It sits directly downstream of the register file: it consumes the busA/busB operands for MULT/MULTU/DIV/DIVU and makes HI or LO available on a result bus that the writeback mux drives onto busW for MFHI/MFLO. A start/busy/done handshake lets the control path stall while an operation runs.

## Interface
- WIDTH, 32, operand and HI/LO width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- busA  input  WIDTH  operand rs (multiplicand/dividend)
- busB  input  WIDTH  operand rt (multiplier/divisor)
- hilo_sel  input  1  0=LO, 1=HI onto result
- result  output  WIDTH  combinational mux of HI/LO by hilo_sel
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; HI/LO hold the new values
- div_by_zero  output  1  pulses with done when DIV/DIVU had busB==0

## Operation
- Reset (reset==0, async): state IDLE, HI=LO=0, counter=0, busy=done=div_by_zero=0, result=0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: with start==1 at edge, latch op, busA, busB, then go to RUN with counter=0. start==0 -> stay.
- RUN: one shift-add step (multiply) or one restoring subtract-shift step (divide) per cycle. Exactly WIDTH steps, then FIX.
- FIX: apply sign correction (see Configuration), then go to DONE.
- DONE: write HI/LO, assert done for one cycle, return to IDLE.
- Multiply: {HI,LO} = the full 2*WIDTH-bit product.
- Divide: LO = quotient, HI = remainder.
- Divide by zero (busB==0): LO=all ones, HI=busA as latched, div_by_zero=1 with done. The full latency still applies.
- start while busy: ignored; no queuing. Operands are captured only at the accepting edge.
- HI/LO keep their values between operations. result reflects the old HI/LO until the DONE edge.

## Timing
- Start accepted at edge 0.
- busy=1 from edge 1 through edge 33, covering the RUN and FIX cycles.
- RUN covers edges 1..32 and FIX is edge 33.
- Edge 34 writes HI/LO, raises done, and drops busy.
- done is high for the cycle after edge 34 only.
- A new start is accepted at the earliest at edge 35; at that edge the FSM is back in IDLE.
- Latency is fixed at 34 cycles from the accepting edge to HI/LO valid, for all ops and all operand values.
- Reset asserted mid-operation aborts immediately to reset values. No partial HI/LO write occurs.

## Configuration
- MULDIV_SIGNED_EN defined:
  - MULT and DIV operate on the magnitudes of the operands.
  - FIX negates the product when the operand signs differ.
  - FIX negates the quotient when the signs differ; the remainder takes the sign of the dividend.
  - Signed divide by zero gives the same forced result as unsigned.
- Not defined: op[0] is ignored, so MULT behaves as MULTU and DIV behaves as DIVU. FIX is a pass-through cycle, so latency is unchanged.

## Structure
- Shared package holds:
  - the op encoding typedef (MULT/MULTU/DIV/DIVU);
  - the FSM state typedef;
  - the constant MULDIV_LATENCY=34.
- One sub-module, muldiv_datapath, holds the shift/accumulate registers and one-step add/subtract logic.
- The top level holds the FSM, the counter, HI/LO, and the output mux.

## Test plan
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done exactly 34 cycles after start, busy low the same cycle.
- MULT (signed build) -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. In the unsigned build the same op gives HI=0x00000004, LO=0xFFFFFFF1.
- DIVU 100/7 -> LO=14, HI=2. DIV (signed build) -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234, div_by_zero=1 coincident with done.
- start pulsed at cycle 10 of a running op with different operands -> ignored; original result is delivered and no second done follows.
- Assert reset at cycle 20 of a DIVU -> busy=done=0 immediately, HI=LO=0. A start after release completes normally in 34 cycles.
